// File: rtl/ecc_44_rd_mon.sv
// Read-side monitor behind the 44-bit SECDED check block: 2-entry skid buffer,
// saturating sbit/dbit counters, first-error address capture and a level irq.
module ecc_44_rd_mon #(
   parameter int DATA_WIDTH    = 44,
   parameter int ADDR_WIDTH    = 8,
   parameter int CNT_WIDTH     = 16,
   parameter int SB_IRQ_THRESH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic                  in_sbit_err,
   input  logic                  in_dbit_err,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_dbit_err,
   output logic [CNT_WIDTH-1:0]  sbit_cnt,
   output logic [CNT_WIDTH-1:0]  dbit_cnt,
   output logic [ADDR_WIDTH-1:0] err_addr,
   output logic                  err_addr_vld,
   output logic                  err_is_dbit,
   output logic                  irq,
   input  logic                  clr
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   localparam logic [CNT_WIDTH-1:0] THRESH = CNT_WIDTH'(SB_IRQ_THRESH);

   state_t                  state;
   logic [DATA_WIDTH-1:0]   sk_data;
   logic                    sk_dbit;
   logic                    accept;
   logic                    emit;
   logic                    load_in;
   logic                    load_sk;
   logic                    pop_sk;
   logic                    sb_inc;
   logic                    db_inc;
   logic [CNT_WIDTH-1:0]    sb_base;
   logic [CNT_WIDTH-1:0]    db_base;
   logic [ADDR_WIDTH-1:0]   addr_base;
   logic                    vld_base;
   logic                    isd_base;

   assign accept = in_valid & in_ready;
   assign emit   = out_valid & out_ready;

   // head register is out_*; the skid slot only fills while the head stalls
   assign load_in = (state == EMPTY && accept) ||
                    (state == ONE && accept && emit);
   assign load_sk = (state == ONE) && accept && !emit;
   assign pop_sk  = (state == TWO) && emit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  state     <= ONE;
                  out_valid <= 1'b1;
               end
            end
            ONE: begin
               if (accept && !emit) begin
                  state    <= TWO;
                  in_ready <= 1'b0;
               end else if (emit && !accept) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
               end
            end
            TWO: begin
               if (emit) begin
                  state    <= ONE;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data     <= '0;
         out_dbit_err <= 1'b0;
      end else if (load_in) begin
         out_data     <= in_data;
         out_dbit_err <= in_dbit_err;
      end else if (pop_sk) begin
         out_data     <= sk_data;
         out_dbit_err <= sk_dbit;
      end
   end

   always_ff @(posedge clk) begin
      if (load_sk) begin
         sk_data <= in_data;
         sk_dbit <= in_dbit_err;
      end
   end

   function automatic logic [CNT_WIDTH-1:0] bump(
      input logic [CNT_WIDTH-1:0] base,
      input logic                 inc
   );
      if (inc && base != '1) return base + 1'b1;
      return base;
   endfunction

   // a dbit flag wins over sbit when both are raised
   assign sb_inc = accept & in_sbit_err & ~in_dbit_err;
   assign db_inc = accept & in_dbit_err;

   // clr applies first, so a beat accepted alongside it is counted afresh
   always_comb begin
      sb_base   = clr ? '0 : sbit_cnt;
      db_base   = clr ? '0 : dbit_cnt;
      addr_base = clr ? '0 : err_addr;
      vld_base  = clr ? 1'b0 : err_addr_vld;
      isd_base  = clr ? 1'b0 : err_is_dbit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sbit_cnt     <= '0;
         dbit_cnt     <= '0;
         err_addr     <= '0;
         err_addr_vld <= 1'b0;
         err_is_dbit  <= 1'b0;
         irq          <= 1'b0;
      end else begin
         sbit_cnt <= bump(sb_base, sb_inc);
         dbit_cnt <= bump(db_base, db_inc);
         if (!vld_base && (sb_inc || db_inc)) begin
            err_addr     <= in_addr;
            err_addr_vld <= 1'b1;
            err_is_dbit  <= in_dbit_err;
         end else if (vld_base && !isd_base && db_inc) begin
            err_addr     <= in_addr;
            err_addr_vld <= 1'b1;
            err_is_dbit  <= 1'b1;
         end else begin
            err_addr     <= addr_base;
            err_addr_vld <= vld_base;
            err_is_dbit  <= isd_base;
         end
         irq <= clr ? 1'b0 : ((dbit_cnt != '0) || (sbit_cnt >= THRESH));
      end
   end

endmodule

// File: tb/tb_ecc_44_rd_mon.sv
// Bench for ecc_44_rd_mon: driver pushes expected beats into a queue,
// a negedge monitor pops and compares every emitted beat.
module tb_ecc_44_rd_mon;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [43:0] in_data;
   logic [7:0]  in_addr;
   logic        in_sbit_err;
   logic        in_dbit_err;
   logic        out_valid;
   logic        out_ready;
   logic [43:0] out_data;
   logic        out_dbit_err;
   logic [15:0] sbit_cnt;
   logic [15:0] dbit_cnt;
   logic [7:0]  err_addr;
   logic        err_addr_vld;
   logic        err_is_dbit;
   logic        irq;
   logic        clr;

   logic        s_in_ready;
   logic        s_out_valid;
   logic [43:0] s_out_data;
   logic        s_out_dbit;
   logic [3:0]  s_sbit_cnt;
   logic [3:0]  s_dbit_cnt;
   logic [7:0]  s_err_addr;
   logic        s_err_vld;
   logic        s_err_isd;
   logic        s_irq;

   int checks   = 0;
   int failures = 0;
   int n_out    = 0;
   logic [44:0] expq[$];
   logic [43:0] hold;
   logic        busy;
   int          n_before;

   always #5 clk = ~clk;

   ecc_44_rd_mon dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_addr(in_addr),
      .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_dbit_err(out_dbit_err),
      .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
      .err_addr(err_addr), .err_addr_vld(err_addr_vld),
      .err_is_dbit(err_is_dbit), .irq(irq), .clr(clr)
   );

   ecc_44_rd_mon #(.CNT_WIDTH(4), .SB_IRQ_THRESH(8)) u_sat (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .in_addr(in_addr),
      .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_data(s_out_data), .out_dbit_err(s_out_dbit),
      .sbit_cnt(s_sbit_cnt), .dbit_cnt(s_dbit_cnt),
      .err_addr(s_err_addr), .err_addr_vld(s_err_vld),
      .err_is_dbit(s_err_isd), .irq(s_irq), .clr(clr)
   );

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_out++;
         if (expq.size() == 0) begin
            check("unexpected_beat", {19'd0, out_dbit_err, out_data}, 64'h1_dead);
         end else begin
            check("beat", {19'd0, out_dbit_err, out_data},
                  {19'd0, expq.pop_front()});
         end
      end
   end

   task automatic send(input logic [43:0] d, input logic [7:0] a,
                       input logic s, input logic db);
      bit ok = 0;
      in_valid    = 1'b1;
      in_data     = d;
      in_addr     = a;
      in_sbit_err = s;
      in_dbit_err = db;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("accept_timeout", 64'd0, 64'd1);
      else expq.push_back({db, d});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         if (expq.size() == 0 && !busy) break;
         tick(1);
      end
      check("drain_empty", 64'(expq.size()), 64'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 0; in_data = '0; in_addr = '0;
      in_sbit_err = 0; in_dbit_err = 0; out_ready = 1; clr = 0; busy = 0;
      tick(2);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_irq", 64'(irq), 64'd0);
      check("rst_cnt", {32'(sbit_cnt), 32'(dbit_cnt)}, 64'd0);
      rst = 1'b0;
      tick(1);

      // 1: single clean beat, one-cycle latency
      send(44'h123_4567_89AB, 8'h01, 0, 0);
      check("lat_out_valid", 64'(out_valid), 64'd1);
      check("lat_out_data", 64'(out_data), 64'h123_4567_89AB);
      tick(2);
      check("clean_cnt", {32'(sbit_cnt), 32'(dbit_cnt)}, 64'd0);
      check("clean_irq", 64'(irq), 64'd0);

      // 2: stall with three back-to-back beats
      out_ready = 1'b0;
      n_before = n_out;
      send(44'hA01, 8'h02, 0, 0);
      send(44'hA02, 8'h03, 0, 0);
      check("full_in_ready", 64'(in_ready), 64'd0);
      hold = out_data;
      busy = 1'b1;
      fork
         begin
            send(44'hA03, 8'h04, 0, 0);
            busy = 1'b0;
         end
      join_none
      tick(3);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_hold", 64'(out_data), 64'(hold));
      check("stall_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      drain();
      tick(2);
      check("stall_count", 64'(n_out - n_before), 64'd3);

      // 3: capture upgrade from sbit to dbit, then hold
      send(44'hB01, 8'h12, 1, 0);
      send(44'hB02, 8'h34, 0, 1);
      tick(2);
      check("cap_addr", 64'(err_addr), 64'h34);
      check("cap_isd", 64'(err_is_dbit), 64'd1);
      check("cap_cnt", {32'(sbit_cnt), 32'(dbit_cnt)}, {32'd1, 32'd1});
      check("cap_irq", 64'(irq), 64'd1);
      send(44'hB03, 8'h56, 0, 1);
      send(44'hB04, 8'h78, 1, 1);
      tick(2);
      check("cap_hold", 64'(err_addr), 64'h34);
      check("illegal_cnt", {32'(sbit_cnt), 32'(dbit_cnt)}, {32'd1, 32'd3});
      pulse_clr();
      check("clr_cnt", {32'(sbit_cnt), 32'(dbit_cnt)}, 64'd0);
      check("clr_cap", {56'd0, err_addr_vld, err_is_dbit, 6'd0}, 64'd0);
      check("clr_irq", 64'(irq), 64'd0);

      // 4: sbit threshold and saturation
      for (int i = 0; i < 16; i++) send(44'(i), 8'(i), 1, 0);
      check("thr_cnt", 64'(sbit_cnt), 64'd16);
      check("thr_irq_before", 64'(irq), 64'd0);
      tick(1);
      check("thr_irq_after", 64'(irq), 64'd1);
      for (int i = 0; i < 4; i++) send(44'(i + 16), 8'h20, 1, 0);
      check("cnt20", 64'(sbit_cnt), 64'd20);
      check("sat15", 64'(s_sbit_cnt), 64'd15);
      tick(1);
      check("sat_irq", 64'(s_irq), 64'd1);
      drain();

      // 5: clr alongside an accepted sbit beat
      clr = 1'b1;
      send(44'hC07, 8'h07, 1, 0);
      clr = 1'b0;
      check("clrbeat_cnt", 64'(sbit_cnt), 64'd1);
      check("clrbeat_addr", 64'(err_addr), 64'h07);
      check("clrbeat_flags", {62'd0, err_addr_vld, err_is_dbit}, 64'b10);
      check("clrbeat_sat", 64'(s_sbit_cnt), 64'd1);
      tick(1);
      check("clrbeat_irq", 64'(irq), 64'd0);
      drain();

      // 6: reset while full, then randomized handshake
      out_ready = 1'b0;
      send(44'hD01, 8'h01, 1, 0);
      send(44'hD02, 8'h02, 0, 0);
      rst = 1'b1;
      #1;
      check("rst2_out_valid", 64'(out_valid), 64'd0);
      check("rst2_in_ready", 64'(in_ready), 64'd1);
      check("rst2_cnt", 64'(sbit_cnt), 64'd0);
      expq.delete();
      tick(1);
      rst = 1'b0;
      tick(1);
      check("rst2_idle", 64'(out_valid), 64'd0);
      n_before = n_out;
      busy = 1'b1;
      fork
         begin
            for (int i = 0; i < 30; i++)
               send({12'($urandom), $urandom}, 8'($urandom),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
            busy = 1'b0;
         end
         begin
            while (busy) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();
      tick(2);
      check("rand_count", 64'(n_out - n_before), 64'd30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
